// File: rtl/dpd_encode_seq.sv
// dpd_encode_seq: sequential BCD-to-DPD significand encoder.
// Packs an N-declet BCD significand into DPD, one 3-digit group per clock,
// LSB group first. Non-decimal nibbles are encoded by the same table and
// reported through a sticky error flag.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous reset, active-high
//   i_valid  input significand valid
//   i_ready  encoder idle, can accept a significand
//   i_bcd    N*12-bit BCD significand, group g = i_bcd[g*12 +: 12]
//   o_valid  encoded result valid, held until o_ready
//   o_ready  consumer accepts the result
//   o_dpd    N*10-bit DPD result, declet g = o_dpd[g*10 +: 10]
//   o_err    some input nibble was > 9 (qualified by o_valid)

module dpd_encode_seq #(
  parameter int unsigned N = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [N*12-1:0]   i_bcd,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [N*10-1:0]   o_dpd,
  output logic              o_err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = N * 12;
  localparam int unsigned DW = N * 10;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   sr_q, sr_d;
  logic [DW-1:0]   dpd_q, dpd_d;
  logic            err_q, err_d;
  logic            o_valid_q, o_valid_d;
  logic            i_ready_q, i_ready_d;

  logic [9:0]      enc_c;
  logic            grp_err_c;

  // Encode one BCD group {a,b,c,d,e,f,g,h,i,j,k,m} into a declet
  // {p,q,r,s,t,u,v,w,x,y}. Large digits (leading bit set) only contribute
  // their LSB; the remaining slots carry the case indicator.
  function automatic logic [9:0] encode_grp(input logic [11:0] grp);
    logic a, b, c, d, e, f, g, h, i, j, k, m;
    logic [9:0] r;
    {a, b, c, d} = grp[11:8];
    {e, f, g, h} = grp[7:4];
    {i, j, k, m} = grp[3:0];
    unique case ({a, e, i})
      3'b000:  r = {b, c, d, f, g, h, 1'b0, j, k, m};
      3'b001:  r = {b, c, d, f, g, h, 1'b1, 1'b0, 1'b0, m};
      3'b010:  r = {b, c, d, j, k, h, 1'b1, 1'b0, 1'b1, m};
      3'b100:  r = {j, k, d, f, g, h, 1'b1, 1'b1, 1'b0, m};
      3'b110:  r = {j, k, d, 1'b0, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
      3'b101:  r = {f, g, d, 1'b0, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
      3'b011:  r = {b, c, d, 1'b1, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
      default: r = {1'b0, 1'b0, d, 1'b1, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
    endcase
    return r;
  endfunction

  // A nibble is non-decimal when its value is 10..15.
  function automatic logic nib_bad(input logic [3:0] nib);
    return nib[3] & (nib[2] | nib[1]);
  endfunction

  // Current group is always the bottom of the shift register.
  always_comb begin
    enc_c     = encode_grp(sr_q[11:0]);
    grp_err_c = nib_bad(sr_q[11:8]) | nib_bad(sr_q[7:4]) | nib_bad(sr_q[3:0]);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    dpd_d     = dpd_q;
    err_d     = err_q;
    o_valid_d = o_valid_q;
    i_ready_d = i_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d   = S_RUN;
          sr_d      = i_bcd;
          cnt_d     = '0;
          dpd_d     = '0;
          err_d     = 1'b0;
          i_ready_d = 1'b0;
        end
      end

      S_RUN: begin
        for (int unsigned gi = 0; gi < N; gi++) begin
          if (cnt_q == CW'(gi)) begin
            dpd_d[gi*10 +: 10] = enc_c;
          end
        end
        err_d = err_q | grp_err_c;
        sr_d  = sr_q >> 12;
        if (cnt_q == LAST) begin
          state_d   = S_DONE;
          o_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        if (o_ready) begin
          state_d   = S_IDLE;
          o_valid_d = 1'b0;
          i_ready_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        o_valid_d = 1'b0;
        i_ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      dpd_q     <= '0;
      err_q     <= 1'b0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      dpd_q     <= dpd_d;
      err_q     <= err_d;
      o_valid_q <= o_valid_d;
      i_ready_q <= i_ready_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_dpd   = dpd_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_dpd_encode_seq.sv
// Testbench for dpd_encode_seq: an N=1 and an N=11 instance, a
// transaction-level reference model, a per-cycle compare process,
// directed literal vectors and randomized handshake traffic.

module tb_dpd_encode_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          iv1, iv11, or1, or11;
  logic [11:0]   bcd1;
  logic [131:0]  bcd11;
  logic          ir1, ov1, oe1, ir11, ov11, oe11;
  logic [9:0]    dpd1;
  logic [109:0]  dpd11;

  dpd_encode_seq #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1), .i_bcd(bcd1),
    .o_valid(ov1), .o_ready(or1), .o_dpd(dpd1), .o_err(oe1)
  );

  dpd_encode_seq #(.N(11)) u_n11 (
    .clk(clk), .rst(rst), .i_valid(iv11), .i_ready(ir11), .i_bcd(bcd11),
    .o_valid(ov11), .o_ready(or11), .o_dpd(dpd11), .o_err(oe11)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference functions ----------------
  // Digit-level DPD encode: a small digit (0..7) keeps its low 3 bits, a
  // large digit keeps only its LSB; the pattern of large digits picks the slots.
  function automatic logic [9:0] ref_enc(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    logic [9:0] r;
    case ({h[3], t[3], u[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, u[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, u[0]};
      3'b010:  r = {h[2:0], u[2:1], t[0], 1'b1, 2'b01, u[0]};
      3'b100:  r = {u[2:1], h[0], t[2:0], 1'b1, 2'b10, u[0]};
      3'b110:  r = {u[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, u[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, u[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, u[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, u[0]};
    endcase
    return r;
  endfunction

  // Standard DPD declet decode back to three BCD digits.
  function automatic logic [11:0] dec(input logic [9:0] c);
    logic [3:0] d2, d1, d0;
    d2 = {1'b0, c[9:7]};
    d1 = {1'b0, c[6:4]};
    d0 = {1'b0, c[2:0]};
    if (c[3]) begin
      case (c[2:1])
        2'b00: d0 = {3'b100, c[0]};
        2'b01: begin d1 = {3'b100, c[4]}; d0 = {1'b0, c[6:5], c[0]}; end
        2'b10: begin d2 = {3'b100, c[7]}; d0 = {1'b0, c[9:8], c[0]}; end
        default: begin
          case (c[6:5])
            2'b00: begin d2 = {3'b100, c[7]}; d1 = {3'b100, c[4]}; d0 = {1'b0, c[9:8], c[0]}; end
            2'b01: begin d2 = {3'b100, c[7]}; d1 = {1'b0, c[9:8], c[4]}; d0 = {3'b100, c[0]}; end
            2'b10: begin d1 = {3'b100, c[4]}; d0 = {3'b100, c[0]}; end
            default: begin d2 = {3'b100, c[7]}; d1 = {3'b100, c[4]}; d0 = {3'b100, c[0]}; end
          endcase
        end
      endcase
    end
    return {d2, d1, d0};
  endfunction

  function automatic logic [110:0] model_result(input logic [131:0] b, input int n);
    logic [109:0] d;
    logic         e;
    logic [11:0]  grp;
    d = '0;
    e = 1'b0;
    for (int g = 0; g < n; g++) begin
      grp = b[g*12 +: 12];
      if (grp[11:8] > 4'd9 || grp[7:4] > 4'd9 || grp[3:0] > 4'd9) e = 1'b1;
      d[g*10 +: 10] = ref_enc(grp[11:8], grp[7:4], grp[3:0]);
    end
    return {e, d};
  endfunction

  function automatic int nn(input int k);
    return (k == 0) ? 1 : 11;
  endfunction

  // ---------------- transaction-level model ----------------
  // m_st: 0 idle, 1 encoding (m_cnt edges left), 2 result held.
  int           m_st   [2];
  int           m_cnt  [2];
  logic [109:0] m_pend [2];
  logic [109:0] m_dpd  [2];
  logic         m_perr [2];
  logic         m_err  [2];
  logic         m_v    [2];
  logic         m_r    [2];
  logic         m_clean[2];
  logic [131:0] m_in   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic         v_in, r_in;
      logic [131:0] b_in;
      logic [110:0] res;
      v_in = (k == 0) ? iv1 : iv11;
      r_in = (k == 0) ? or1 : or11;
      b_in = (k == 0) ? 132'(bcd1) : bcd11;
      if (rst) begin
        m_st[k] = 0; m_v[k] = 1'b0; m_r[k] = 1'b1; m_clean[k] = 1'b1;
      end else begin
        case (m_st[k])
          0: if (v_in) begin
            res       = model_result(b_in, nn(k));
            m_pend[k] = res[109:0];
            m_perr[k] = res[110];
            m_in[k]   = b_in;
            m_st[k]   = 1;
            m_cnt[k]  = nn(k);
            m_r[k]    = 1'b0;
            m_clean[k] = 1'b0;
          end
          1: begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_st[k] = 2; m_v[k] = 1'b1; m_dpd[k] = m_pend[k]; m_err[k] = m_perr[k];
            end
          end
          default: if (r_in) begin
            m_st[k] = 0; m_v[k] = 1'b0; m_r[k] = 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic         a_v, a_r, a_e;
        logic [109:0] a_d;
        a_v = (k == 0) ? ov1 : ov11;
        a_r = (k == 0) ? ir1 : ir11;
        a_e = (k == 0) ? oe1 : oe11;
        a_d = (k == 0) ? 110'(dpd1) : dpd11;
        chk("o_valid", 128'(a_v), 128'(m_v[k]));
        chk("i_ready", 128'(a_r), 128'(m_r[k]));
        if (m_v[k]) begin
          chk("o_dpd", 128'(a_d), 128'(m_dpd[k]));
          chk("o_err", 128'(a_e), 128'(m_err[k]));
          if (!m_err[k]) begin
            for (int g = 0; g < nn(k); g++)
              chk("roundtrip", 128'(dec(a_d[g*10 +: 10])), 128'(m_in[k][g*12 +: 12]));
          end
        end
        if (m_clean[k]) begin
          chk("o_dpd_clear", 128'(a_d), 128'(0));
          chk("o_err_clear", 128'(a_e), 128'(0));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic xact(input int k, input logic [131:0] b, input int hold,
                      output logic [109:0] d, output logic e, output int lat);
    int t;
    t = 0;
    while (!((k == 0) ? ir1 : ir11) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ready_timeout", 128'(0), 128'(1));
    if (k == 0) begin iv1 = 1'b1; bcd1 = b[11:0]; end
    else        begin iv11 = 1'b1; bcd11 = b; end
    @(negedge clk);
    if (k == 0) iv1 = 1'b0; else iv11 = 1'b0;
    lat = 0;
    while (!((k == 0) ? ov1 : ov11) && lat < 60) begin @(negedge clk); lat++; end
    if (lat >= 60) chk("valid_timeout", 128'(0), 128'(1));
    d = (k == 0) ? 110'(dpd1) : dpd11;
    e = (k == 0) ? oe1 : oe11;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'((k == 0) ? ov1 : ov11), 128'(1));
      chk("bp_dpd",   128'((k == 0) ? 110'(dpd1) : dpd11), 128'(d));
      chk("bp_ready", 128'((k == 0) ? ir1 : ir11), 128'(0));
    end
    if (k == 0) or1 = 1'b1; else or11 = 1'b1;
    @(negedge clk);
    if (k == 0) or1 = 1'b0; else or11 = 1'b0;
    chk("release_valid", 128'((k == 0) ? ov1 : ov11), 128'(0));
    chk("release_ready", 128'((k == 0) ? ir1 : ir11), 128'(1));
  endtask

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 15) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  function automatic logic [131:0] rnd_bcd();
    logic [131:0] b;
    for (int i = 0; i < 33; i++) b[i*4 +: 4] = rnd_nib();
    return b;
  endfunction

  // ---------------- main sequence ----------------
  logic [11:0] vin  [7] = '{12'h000, 12'h005, 12'h008, 12'h080, 12'h800, 12'h123, 12'h999};
  logic [9:0]  vout [7] = '{10'h000, 10'h005, 10'h008, 10'h00A, 10'h00C, 10'h0A3, 10'h0FF};

  initial begin
    logic [109:0] d;
    logic         e;
    int           lat;
    logic [131:0] b;
    rst = 1'b1; iv1 = 1'b0; iv11 = 1'b0; or1 = 1'b0; or11 = 1'b0;
    bcd1 = '0; bcd11 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready1",  128'(ir1), 128'(1));
    chk("reset_valid1",  128'(ov1), 128'(0));
    chk("reset_dpd11",   128'(dpd11), 128'(0));
    chk("reset_err11",   128'(oe11), 128'(0));
    chk_en = 1'b1;

    // N=1 case codes with literal results and 1-cycle latency
    for (int i = 0; i < 7; i++) begin
      xact(0, 132'(vin[i]), 0, d, e, lat);
      chk("n1_vec_dpd", 128'(d[9:0]), 128'(vout[i]));
      chk("n1_vec_err", 128'(e), 128'(0));
      chk("n1_latency", 128'(lat), 128'(1));
    end

    // Invalid tens nibble: e=1 case of the table gives 0x0AB, error set
    xact(0, 132'(12'h1A3), 0, d, e, lat);
    chk("inv_dpd", 128'(d[9:0]), 128'(10'h0AB));
    chk("inv_err", 128'(e), 128'(1));
    xact(0, 132'(12'h123), 0, d, e, lat);
    chk("after_inv_err", 128'(e), 128'(0));

    // Exhaustive round trip of every decimal triple
    for (int v = 0; v < 1000; v++) begin
      logic [11:0] g;
      g = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      xact(0, 132'(g), 0, d, e, lat);
      chk("exh_roundtrip", 128'(dec(d[9:0])), 128'(g));
      chk("exh_err", 128'(e), 128'(0));
    end

    // N=11 full significand with 20 cycles of backpressure
    b = {{10{12'h999}}, 12'h123};
    xact(1, b, 20, d, e, lat);
    chk("n11_dpd", 128'(d), 128'({{10{10'h0FF}}, 10'h0A3}));
    chk("n11_err", 128'(e), 128'(0));
    chk("n11_latency", 128'(lat), 128'(11));

    // Sticky error from a single middle group
    b = '0;
    b[5*12 +: 12] = 12'hF00;
    xact(1, b, 0, d, e, lat);
    chk("n11_sticky_err", 128'(e), 128'(1));

    // Reset at T+5 aborts the transaction
    iv11 = 1'b1; bcd11 = {{10{12'h999}}, 12'h123};
    @(negedge clk);
    iv11 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 128'(ir11), 128'(1));
    chk("abort_valid", 128'(ov11), 128'(0));
    chk("abort_dpd",   128'(dpd11), 128'(0));
    chk("abort_err",   128'(oe11), 128'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 128'(ov11), 128'(0));
    end

    // Randomized traffic on both instances, occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      iv1   = 1'($urandom_range(0, 1));
      iv11  = 1'($urandom_range(0, 1));
      or1   = 1'($urandom_range(0, 2) != 0);
      or11  = 1'($urandom_range(0, 3) == 0);
      b     = rnd_bcd();
      bcd1  = b[11:0];
      bcd11 = rnd_bcd();
    end
    @(negedge clk);
    rst = 1'b0; iv1 = 1'b0; iv11 = 1'b0; or1 = 1'b1; or11 = 1'b1;
    repeat (16) @(negedge clk);
    chk("drain_ready1",  128'(ir1), 128'(1));
    chk("drain_ready11", 128'(ir11), 128'(1));
    or1 = 1'b0; or11 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
